vga_video_out: RTL and testbench
================================

// Module: vga_video_out
// PURPOSE
//  Parametrised successor to the fixed 640x480 VGA output stage. Generates programmable
//  H/V timing, issues pixel read requests ahead of time, and realigns sync/video/coords
//  with pixel data returned by a fixed-latency source (frame buffer or BRAM). Built-in
//  test-pattern modes switch only at frame boundaries. Sits between frame buffer and pins.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line (multiple of 8) | H_FP 16 | H_SYNC 96 | H_BP 48
//  V_ACTIVE 480 visible lines | V_FP 10 | V_SYNC 2 | V_BP 33
//  HS_POL 0  hsync active level (0 = active-low) | VS_POL 0  vsync active level
//  COLOR_W 4  bits per colour channel
//  RD_LAT 2  pixel-source read latency in cycles, 0..7
//  XW/YW: localparams, $clog2(H_TOTAL)/$clog2(V_TOTAL) (10/10 at defaults)
// PORTS
//  i_clk           in   1          pixel clock
//  i_rst           in   1          synchronous reset, active-high
//  i_en            in   1          1 = timing runs; 0 = counters held at (0,0)
//  i_mode          in   2          0 ext pixel, 1 colour bars, 2 checker, 3 solid
//  i_solid         in   3*COLOR_W  {R,G,B} for mode 3
//  i_pixel_data    in   3*COLOR_W  {R,G,B} from source, valid RD_LAT cycles after o_rd_en
//  o_rd_en         out  1          read request, high for visible pixels only
//  o_rd_x/o_rd_y   out  XW/YW      request coordinates
//  o_VGA_x/_y      out  XW/YW      coordinates aligned with colour outputs
//  o_VGA_hsync     out  1          horizontal sync, polarity HS_POL
//  o_VGA_vsync     out  1          vertical sync, polarity VS_POL
//  o_VGA_video     out  1          visible-area flag, aligned with colour
//  o_VGA_red/green/blue out COLOR_W  colour, forced 0 when o_VGA_video=0
//  o_frame_start   out  1          1-cycle pulse with output pixel (0,0)
// BEHAVIOUR
//  - H_TOTAL=sum of H params (800), V_TOTAL=sum of V params (525). h_cnt 0..H_TOTAL-1; wrap
//    to 0 increments v_cnt; v_cnt wraps V_TOTAL-1 -> 0. Both advance only while i_en=1.
//  - active = h<H_ACTIVE && v<V_ACTIVE. hsync active for h in [H_ACTIVE+H_FP,
//    H_ACTIVE+H_FP+H_SYNC); vsync active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
//  - Stage 0 (cycle t): counters. Stage 1 (t+1): o_rd_en/o_rd_x/o_rd_y registered.
//    Source data sampled at edge t+1+RD_LAT. Output regs update at t+2+RD_LAT.
//    hsync/vsync/video/x/y travel an RD_LAT+1 deep shift register -> all outputs aligned.
//    Total counter->pin latency = RD_LAT+2 cycles, constant, incl. RD_LAT=0.
//  - Mode: i_mode and i_solid latched into mode_q only when stage-0 (h,v)=(0,0);
//    mid-frame changes take effect on the next frame. Reset sets mode_q=0.
//  - Colour bars: bar=x/(H_ACTIVE/8) via comparators; order white, yellow, cyan, green,
//    magenta, red, blue, black; full-scale = all-ones COLOR_W. Checker: x[5]^y[5] ->
//    white/black (32x32). Patterns computed from delayed x/y in output stage.
//  - Reset and i_en=0: counters->(0,0), delay lines flushed to idle; outputs idle:
//    sync at inactive level (~HS_POL/~VS_POL), video/rd_en/frame_start/colour=0, x/y=0.
//    i_en falling mid-line: idle is reached at output after RD_LAT+2 cycles; i_en rising
//    restarts a full frame from (0,0) with frame_start after RD_LAT+2 cycles.
//  - No partial frames after reset: first output frame is complete.
// TESTING
//  1 Assert i_rst 3 cycles -> hsync=vsync=1, video=0, RGB=0, rd_en=0, frame_start=0.
//  2 Defaults, mode 0 -> hsync low exactly 96 cycles per 800; vsync low 2 lines per 525;
//    video high 640 cycles/line on 480 lines; frame_start every 420000 cycles.
//  3 RD_LAT=2, model RAM returns data=x -> output RGB equals o_VGA_x on every visible
//    pixel; o_VGA_x=0 appears 4 cycles after stage-0 h=0.
//  4 Mode 1 -> at x=0 RGB=FFF, x=80 FF0, x=560 000; mode 2 -> (32,0)=000, (32,32)=FFF.
//  5 Switch i_mode 0->3 (solid 0x123) at line 100 -> rest of frame from source,
//    next frame all visible pixels 0x123.
//  6 Small params (H 8/1/2/1, V 4/1/1/1), drop i_en mid-line, RD_LAT=0 and 7 -> idle
//    outputs after RD_LAT+2 cycles; re-enable -> frame_start after RD_LAT+2 cycles.

Source files
------------

// File: rtl/vga_video_out.sv
// Parametrised VGA output stage: programmable H/V timing, early pixel read requests,
// and realignment of sync/video/coordinates with fixed-latency source pixel data.
module vga_video_out #(
    parameter int unsigned  H_ACTIVE = 640,
    parameter int unsigned  H_FP     = 16,
    parameter int unsigned  H_SYNC   = 96,
    parameter int unsigned  H_BP     = 48,
    parameter int unsigned  V_ACTIVE = 480,
    parameter int unsigned  V_FP     = 10,
    parameter int unsigned  V_SYNC   = 2,
    parameter int unsigned  V_BP     = 33,
    parameter bit           HS_POL   = 1'b0,
    parameter bit           VS_POL   = 1'b0,
    parameter int unsigned  COLOR_W  = 4,
    parameter int unsigned  RD_LAT   = 2,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW       = $clog2(H_TOTAL),
    localparam int unsigned YW       = $clog2(V_TOTAL),
    localparam int unsigned PW       = 3 * COLOR_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [1:0]         i_mode,
    input  logic [PW-1:0]      i_solid,
    input  logic [PW-1:0]      i_pixel_data,
    output logic               o_rd_en,
    output logic [XW-1:0]      o_rd_x,
    output logic [YW-1:0]      o_rd_y,
    output logic [XW-1:0]      o_VGA_x,
    output logic [YW-1:0]      o_VGA_y,
    output logic               o_VGA_hsync,
    output logic               o_VGA_vsync,
    output logic               o_VGA_video,
    output logic [COLOR_W-1:0] o_VGA_red,
    output logic [COLOR_W-1:0] o_VGA_green,
    output logic [COLOR_W-1:0] o_VGA_blue,
    output logic               o_frame_start
);

    localparam logic [XW-1:0] H_ACT_X  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] V_ACT_Y  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam int unsigned   BAR_W    = H_ACTIVE / 8;

    // One pixel's worth of side-band information travelling alongside the read.
    typedef struct packed {
        logic          video;
        logic          hs;
        logic          vs;
        logic          fs;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [1:0]    mode;
        logic [PW-1:0] solid;
    } side_t;

    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] solid_q, solid_d;
    side_t         side_d;
    side_t         dl_q [RD_LAT+1];
    side_t         out_s;

    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          video_q, video_d;
    logic          fs_q, fs_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [PW-1:0] rgb_q, rgb_d;

    logic [2:0]    bar;
    logic [PW-1:0] bar_rgb;
    logic          x_b5;
    logic          y_b5;

    // Stage 0: timing counters, mode latch at frame origin, side-band decode.
    always_comb begin
        h_d     = '0;
        v_d     = '0;
        mode_d  = mode_q;
        solid_d = solid_q;
        side_d  = '0;
        if (i_en) begin
            if ((h_q == '0) && (v_q == '0)) begin
                mode_d  = i_mode;
                solid_d = i_solid;
            end
            side_d.video = (h_q < H_ACT_X) && (v_q < V_ACT_Y);
            side_d.hs    = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
            side_d.vs    = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
            side_d.fs    = (h_q == '0) && (v_q == '0);
            side_d.x     = h_q;
            side_d.y     = v_q;
            side_d.mode  = mode_d;
            side_d.solid = solid_d;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
            end else begin
                h_d = h_q + XW'(1);
                v_d = v_q;
            end
        end
    end

    assign out_s = dl_q[RD_LAT];

    generate
        if (XW > 5) begin : g_xb
            assign x_b5 = out_s.x[5];
        end else begin : g_xn
            assign x_b5 = 1'b0;
        end
        if (YW > 5) begin : g_yb
            assign y_b5 = out_s.y[5];
        end else begin : g_yn
            assign y_b5 = 1'b0;
        end
    endgenerate

    // Colour-bar index from threshold comparators; bar order encodes RGB as inverted bits.
    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (out_s.x >= XW'(k * int'(BAR_W))) begin
                bar = 3'(k);
            end
        end
        bar_rgb = {{COLOR_W{~bar[1]}}, {COLOR_W{~bar[2]}}, {COLOR_W{~bar[0]}}};
    end

    // Output stage: pattern select and blanking, aligned with returned source data.
    always_comb begin
        hs_d    = out_s.hs ? HS_POL : ~HS_POL;
        vs_d    = out_s.vs ? VS_POL : ~VS_POL;
        video_d = out_s.video;
        fs_d    = out_s.fs;
        x_d     = out_s.x;
        y_d     = out_s.y;
        case (out_s.mode)
            2'd0:    rgb_d = i_pixel_data;
            2'd1:    rgb_d = bar_rgb;
            2'd2:    rgb_d = {PW{~(x_b5 ^ y_b5)}};
            default: rgb_d = out_s.solid;
        endcase
        if (!out_s.video) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q     <= '0;
            v_q     <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            for (int i = 0; i <= int'(RD_LAT); i++) begin
                dl_q[i] <= '0;
            end
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            video_q <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            dl_q[0] <= side_d;
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                dl_q[i] <= dl_q[i-1];
            end
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            video_q <= video_d;
            fs_q    <= fs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rgb_q   <= rgb_d;
        end
    end

    assign o_rd_en       = dl_q[0].video;
    assign o_rd_x        = dl_q[0].x;
    assign o_rd_y        = dl_q[0].y;
    assign o_VGA_x       = x_q;
    assign o_VGA_y       = y_q;
    assign o_VGA_hsync   = hs_q;
    assign o_VGA_vsync   = vs_q;
    assign o_VGA_video   = video_q;
    assign o_VGA_red     = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign o_VGA_green   = rgb_q[2*COLOR_W-1:COLOR_W];
    assign o_VGA_blue    = rgb_q[COLOR_W-1:0];
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_video_out.sv
// Bench for vga_video_out: three instances (medium timing RD_LAT=2, tiny timing RD_LAT=0/7)
// driven with random enables/modes and checked every cycle against a frame-position model.
module tb_vga_video_out;

    localparam int unsigned CW   = 4;
    localparam int unsigned PW   = 12;
    localparam int          NI   = 3;
    localparam int          NCYC = 17000;

    typedef struct packed {
        logic        vid;
        logic        hsa;
        logic        vsa;
        logic        fs;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] c;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en [NI];
    logic [1:0]    mode;
    logic [PW-1:0] solid;
    logic [PW-1:0] seed;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] src_pix(input int x, input int y);
        return PW'(x * 37 + y * 101) ^ seed;
    endfunction

    function automatic logic [11:0] exp_col(input logic [1:0] m, input logic [11:0] s,
                                            input int h, input int v, input int ha);
        logic [11:0] bars [8];
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        case (m)
            2'd0:    return src_pix(h, v);
            2'd1:    return bars[h * 8 / ha];
            2'd2:    return (((h / 32) % 2) != ((v / 32) % 2)) ? 12'h000 : 12'hFFF;
            default: return s;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int unsigned HA  = (g == 0) ? 64 : 8;
        localparam int unsigned HF  = (g == 0) ? 4 : 1;
        localparam int unsigned HS  = (g == 0) ? 8 : 2;
        localparam int unsigned HB  = (g == 0) ? 4 : 1;
        localparam int unsigned VA  = (g == 0) ? 40 : 4;
        localparam int unsigned VF  = (g == 0) ? 2 : 1;
        localparam int unsigned VS  = (g == 0) ? 2 : 1;
        localparam int unsigned VB  = (g == 0) ? 3 : 1;
        localparam bit          HP  = (g == 1);
        localparam bit          VP  = (g == 2);
        localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 0 : 7);
        localparam int          HT  = int'(HA + HF + HS + HB);
        localparam int          VT  = int'(VA + VF + VS + VB);
        localparam int unsigned XW  = $clog2(HT);
        localparam int unsigned YW  = $clog2(VT);
        localparam int          SI  = (LAT == 0) ? 0 : int'(LAT) - 1;
        localparam int          OI  = int'(LAT) + 1;

        logic          rd_en, hs, vs, video, fs;
        logic [XW-1:0] rd_x, vx;
        logic [YW-1:0] rd_y, vy;
        logic [CW-1:0] r, gg, b;
        logic [PW-1:0] pix, junk;
        logic          sp_v [8];
        int            sp_x [8];
        int            sp_y [8];
        rec_t          hist [9];
        int            pos;
        logic [1:0]    mm;
        logic [PW-1:0] ms;

        vga_video_out #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .HS_POL(HP), .VS_POL(VP), .COLOR_W(CW), .RD_LAT(LAT)
        ) dut (
            .i_clk(clk), .i_rst(rst), .i_en(en[g]), .i_mode(mode), .i_solid(solid),
            .i_pixel_data(pix), .o_rd_en(rd_en), .o_rd_x(rd_x), .o_rd_y(rd_y),
            .o_VGA_x(vx), .o_VGA_y(vy), .o_VGA_hsync(hs), .o_VGA_vsync(vs),
            .o_VGA_video(video), .o_VGA_red(r), .o_VGA_green(gg), .o_VGA_blue(b),
            .o_frame_start(fs)
        );

        // Pixel source with LAT cycles of read latency; garbage when no request is pending.
        always @(posedge clk) begin
            sp_v[0] <= rd_en;
            sp_x[0] <= int'(rd_x);
            sp_y[0] <= int'(rd_y);
            for (int i = 1; i < 8; i++) begin
                sp_v[i] <= sp_v[i-1];
                sp_x[i] <= sp_x[i-1];
                sp_y[i] <= sp_y[i-1];
            end
            junk <= PW'($urandom);
        end

        always_comb begin
            pix = junk;
            if (LAT == 0) begin
                if (rd_en) pix = src_pix(int'(rd_x), int'(rd_y));
            end else if (sp_v[SI]) begin
                pix = src_pix(sp_x[SI], sp_y[SI]);
            end
        end

        // Reference: position counts enabled cycles since reset/disable; expected pins follow
        // the frame position after a fixed LAT+2 cycle delay.
        initial begin : model
            rec_t e;
            int   h, v;
            pos = 0;
            mm  = '0;
            ms  = '0;
            forever begin
                @(posedge clk);
                e = '0;
                if (rst) begin
                    pos = 0;
                    mm  = '0;
                    ms  = '0;
                    for (int i = 0; i < 9; i++) hist[i] = '0;
                end else begin
                    if (en[g]) begin
                        h = pos % HT;
                        v = (pos / HT) % VT;
                        if (pos % (HT * VT) == 0) begin
                            mm = mode;
                            ms = solid;
                        end
                        e.vid = (h < int'(HA)) && (v < int'(VA));
                        e.hsa = (h >= int'(HA + HF)) && (h < int'(HA + HF + HS));
                        e.vsa = (v >= int'(VA + VF)) && (v < int'(VA + VF + VS));
                        e.fs  = (pos % (HT * VT) == 0);
                        e.x   = 8'(h);
                        e.y   = 8'(v);
                        if (e.vid) e.c = exp_col(mm, ms, h, v, int'(HA));
                        pos = pos + 1;
                    end else begin
                        pos = 0;
                    end
                    for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = e;
                end
                @(negedge clk);
                e = hist[OI];
                check($sformatf("i%0d_pins", g),
                      64'({hs, vs, video, fs, 8'(vx), 8'(vy), r, gg, b}),
                      64'({(e.hsa ? HP : ~HP), (e.vsa ? VP : ~VP), e.vid, e.fs, e.x, e.y, e.c}));
                check($sformatf("i%0d_rd", g),
                      64'({rd_en, 8'(rd_x), 8'(rd_y)}),
                      64'({hist[0].vid, hist[0].x, hist[0].y}));
            end
        end
    end

    initial begin
        logic [1:0] mseq [4];
        mseq  = '{2'd3, 2'd1, 2'd2, 2'd0};
        seed  = PW'($urandom);
        rst   = 1'b1;
        mode  = 2'd0;
        solid = '0;
        for (int i = 0; i < NI; i++) en[i] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (c % 4000 == 1000) mode = mseq[(c / 4000) % 4];
            if (c % 700 == 350) solid = PW'($urandom);
            if (c == 15000) en[0] = 1'b0;
            if (c == 15040) en[0] = 1'b1;
            for (int i = 1; i < NI; i++) begin
                if (en[i]) begin
                    if ($urandom_range(149) == 0) en[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    en[i] = 1'b1;
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
